// File: rtl/uart_led_frame_parser.sv
// Purpose: decodes framed LED commands (55 A5 T3 T2 T1 T0 CTRL CHK F0) from a UART byte stream.
// Latency: led_ctrl/led_time_set/frame_ok update 1 cycle after the tail byte's rx_done.
// Backpressure: none; every rx_done byte is consumed, and bad or stale frames are dropped with frame_err.
// Ports: Clk/Reset (sync, active-high); rx_data/rx_done byte strobe in;
//        led_ctrl/led_time_set registered LED settings out; frame_ok/frame_err 1-cycle status pulses.
module uart_led_frame_parser #(
    parameter logic [7:0]  HEAD0          = 8'h55,
    parameter logic [7:0]  HEAD1          = 8'hA5,
    parameter logic [7:0]  TAIL           = 8'hF0,
    parameter int unsigned TIMEOUT_CYCLES = 500_000,
    parameter logic [31:0] DEFAULT_TIME   = 32'd25_000_000,
    parameter logic [7:0]  DEFAULT_CTRL   = 8'h00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  led_ctrl,
    output logic [31:0] led_time_set,
    output logic        frame_ok,
    output logic        frame_err
);

    // Counter only ever needs to hold TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_CHK,
        S_TL
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [31:0]   sh_time_q, sh_time_d;
    logic [7:0]    sh_ctrl_q, sh_ctrl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    led_ctrl_q, led_ctrl_d;
    logic [31:0]   led_time_q, led_time_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        sh_time_d   = sh_time_q;
        sh_ctrl_d   = sh_ctrl_q;
        cnt_d       = cnt_q;
        led_ctrl_d  = led_ctrl_q;
        led_time_d  = led_time_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;

        if (rx_done) begin
            // A byte arriving on the expiry cycle takes priority over the timeout.
            cnt_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == HEAD0) state_d = S_HDR;
                end
                S_HDR: begin
                    if (rx_data == HEAD1) begin
                        state_d = S_PAYLOAD;
                        idx_d   = 3'd0;
                        sum_d   = 8'h00;
                    end else if (rx_data != HEAD0) begin
                        state_d = S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    // Header bytes here are plain data: no resync once the payload has started.
                    sum_d = sum_q ^ rx_data;
                    idx_d = idx_q + 3'd1;
                    if (idx_q != 3'd4) begin
                        sh_time_d = {sh_time_q[23:0], rx_data};
                    end else begin
                        sh_ctrl_d = rx_data;
                        state_d   = S_CHK;
                    end
                end
                S_CHK: begin
                    if (rx_data == sum_q) begin
                        state_d = S_TL;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_TL: begin
                    if (rx_data == TAIL && sh_time_q != 32'd0) begin
                        led_time_d = sh_time_q;
                        led_ctrl_d = sh_ctrl_q;
                        frame_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            sum_q       <= 8'h00;
            sh_time_q   <= 32'd0;
            sh_ctrl_q   <= 8'h00;
            cnt_q       <= '0;
            led_ctrl_q  <= DEFAULT_CTRL;
            led_time_q  <= DEFAULT_TIME;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            sh_time_q   <= sh_time_d;
            sh_ctrl_q   <= sh_ctrl_d;
            cnt_q       <= cnt_d;
            led_ctrl_q  <= led_ctrl_d;
            led_time_q  <= led_time_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign led_ctrl     = led_ctrl_q;
    assign led_time_set = led_time_q;
    assign frame_ok     = frame_ok_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_led_frame_parser.sv
// Purpose: randomized and directed stimulus for uart_led_frame_parser against a byte-list reference model.
// Latency: expects output updates 1 cycle after each sampled byte.
// Backpressure: none; bytes are strobed with arbitrary gaps, including around the timeout boundary.
module tb_uart_led_frame_parser;

    localparam int TO = 40;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [7:0]  led_ctrl;
    logic [31:0] led_time_set;
    logic        frame_ok;
    logic        frame_err;

    uart_led_frame_parser #(
        .HEAD0          (8'h55),
        .HEAD1          (8'hA5),
        .TAIL           (8'hF0),
        .TIMEOUT_CYCLES (TO),
        .DEFAULT_TIME   (32'd25_000_000),
        .DEFAULT_CTRL   (8'h00)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .led_ctrl     (led_ctrl),
        .led_time_set (led_time_set),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int ok_seen = 0;
    int err_seen = 0;

    // Reference model: bytes of the frame collected so far, and idle cycles since the last byte.
    logic [7:0]  mbuf[$];
    int          m_idle = 0;
    logic [7:0]  m_ctrl = 8'h00;
    logic [31:0] m_time = 32'd25_000_000;
    logic        m_ok = 1'b0;
    logic        m_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic dn, input logic [7:0] d);
        logic [7:0]  x;
        logic [31:0] t;
        m_ok  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_ctrl = 8'h00;
            m_time = 32'd25_000_000;
            mbuf.delete();
            m_idle = 0;
        end else if (dn) begin
            m_idle = 0;
            case (mbuf.size())
                0: if (d == 8'h55) mbuf.push_back(d);
                1: begin
                    if (d == 8'hA5) mbuf.push_back(d);
                    else if (d != 8'h55) mbuf.delete();
                end
                7: begin
                    x = mbuf[2] ^ mbuf[3] ^ mbuf[4] ^ mbuf[5] ^ mbuf[6];
                    if (d == x) mbuf.push_back(d);
                    else begin
                        m_err = 1'b1;
                        mbuf.delete();
                    end
                end
                8: begin
                    t = {mbuf[2], mbuf[3], mbuf[4], mbuf[5]};
                    if (d == 8'hF0 && t != 32'd0) begin
                        m_time = t;
                        m_ctrl = mbuf[6];
                        m_ok   = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    mbuf.delete();
                end
                default: mbuf.push_back(d);
            endcase
        end else if (mbuf.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_err = 1'b1;
                mbuf.delete();
                m_idle = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input logic rst, input logic dn, input logic [7:0] d);
        Reset   = rst;
        rx_done = dn;
        rx_data = d;
        model_step(rst, dn, d);
        @(posedge Clk);
        #1;
        if (frame_ok) ok_seen++;
        if (frame_err) err_seen++;
        check("cycle", {22'd0, frame_ok, frame_err, led_ctrl, led_time_set},
                       {22'd0, m_ok, m_err, m_ctrl, m_time});
        Reset   = 1'b0;
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        cycle(1'b0, 1'b1, b);
    endtask

    // Full frame; chkx flips checksum bits, tl is the tail byte, one byte gets a custom leading gap.
    task automatic send_frame(input logic [31:0] t, input logic [7:0] c, input logic [7:0] chkx,
                              input logic [7:0] tl, input int gap_pos, input int gap_len);
        logic [7:0] b[9];
        b[0] = 8'h55; b[1] = 8'hA5;
        b[2] = t[31:24]; b[3] = t[23:16]; b[4] = t[15:8]; b[5] = t[7:0];
        b[6] = c;
        b[7] = (t[31:24] ^ t[23:16] ^ t[15:8] ^ t[7:0] ^ c) ^ chkx;
        b[8] = tl;
        for (int i = 0; i < 9; i++)
            send(b[i], (i == gap_pos) ? gap_len : int'($urandom_range(0, 2)));
    endtask

    int ok0, err0, kind;

    initial begin
        // Reset values
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        check("rst_ctrl", {56'd0, led_ctrl}, 64'h00);
        check("rst_time", {32'd0, led_time_set}, 64'd25_000_000);
        check("rst_pulses", {62'd0, frame_ok, frame_err}, 64'd0);

        // Valid frame: 10_000_000 / A5
        ok0 = ok_seen; err0 = err_seen;
        send_frame(32'h0098_9680, 8'hA5, 8'h00, 8'hF0, -1, 0);
        idle(2);
        check("valid_time", {32'd0, led_time_set}, 64'd10_000_000);
        check("valid_ctrl", {56'd0, led_ctrl}, 64'hA5);
        check("valid_ok_cnt", 64'(ok_seen - ok0), 64'd1);

        // Bad checksum: one err, trailing F0 ignored, outputs unchanged
        ok0 = ok_seen; err0 = err_seen;
        send_frame(32'h0000_1234, 8'h3C, 8'h01, 8'hF0, -1, 0);
        idle(2);
        check("badchk_err_cnt", 64'(err_seen - err0), 64'd1);
        check("badchk_ok_cnt", 64'(ok_seen - ok0), 64'd0);
        check("badchk_time", {32'd0, led_time_set}, 64'd10_000_000);

        // Garbage then header resync
        ok0 = ok_seen; err0 = err_seen;
        send(8'h12, 1); send(8'h34, 1); send(8'h55, 1);
        send_frame(32'h0000_0100, 8'h0F, 8'h00, 8'hF0, -1, 0);
        idle(2);
        check("resync_ok_cnt", 64'(ok_seen - ok0), 64'd1);
        check("resync_err_cnt", 64'(err_seen - err0), 64'd0);
        check("resync_time", {32'd0, led_time_set}, 64'h100);

        // Timeout mid-payload, then recovery
        ok0 = ok_seen; err0 = err_seen;
        send(8'h55, 0); send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
        idle(TO + 5);
        check("timeout_err_cnt", 64'(err_seen - err0), 64'd1);
        send_frame(32'h0000_0200, 8'h11, 8'h00, 8'hF0, 4, TO - 1);
        idle(2);
        check("after_to_ok_cnt", 64'(ok_seen - ok0), 64'd1);
        check("after_to_ctrl", {56'd0, led_ctrl}, 64'h11);

        // Zero time rejected
        ok0 = ok_seen; err0 = err_seen;
        send_frame(32'h0, 8'h77, 8'h00, 8'hF0, -1, 0);
        idle(2);
        check("zero_err_cnt", 64'(err_seen - err0), 64'd1);
        check("zero_ctrl", {56'd0, led_ctrl}, 64'h11);

        // Reset after T1, then a fresh frame
        send(8'h55, 0); send(8'hA5, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
        cycle(1'b1, 1'b0, 8'h00);
        check("midrst_time", {32'd0, led_time_set}, 64'd25_000_000);
        send(8'h04, 1); send(8'h09, 1);
        send_frame(32'h0000_0300, 8'h22, 8'h00, 8'hF0, -1, 0);
        idle(2);
        check("midrst_time2", {32'd0, led_time_set}, 64'h300);
        check("midrst_ctrl2", {56'd0, led_ctrl}, 64'h22);

        // Randomized mix against the model
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0: for (int k = 0; k < int'($urandom_range(1, 3)); k++)
                       send(8'($urandom), int'($urandom_range(0, 3)));
                1: send_frame($urandom, 8'($urandom), 8'($urandom_range(1, 255)), 8'hF0, -1, 0);
                2: send_frame($urandom, 8'($urandom), 8'h00, 8'($urandom), -1, 0);
                3: send_frame(32'h0, 8'($urandom), 8'h00, 8'hF0, -1, 0);
                4: send_frame($urandom, 8'($urandom), 8'h00, 8'hF0,
                              int'($urandom_range(1, 8)), int'($urandom_range(TO - 2, TO + 1)));
                5: begin
                    send(8'h55, 0); send(8'hA5, 0); send(8'($urandom), 1);
                    cycle(1'b1, 1'b0, 8'h00);
                end
                6: send_frame({8'h55, 8'($urandom), 8'h55, 8'hA5}, 8'h55, 8'h00, 8'hF0, -1, 0);
                default: send_frame($urandom, 8'($urandom), 8'h00, 8'hF0, -1, 0);
            endcase
        end
        idle(TO + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
